sram_addr_ctr: RTL
==================

Name: sram_addr_ctr

Overview:
- Address stage between the serial address shift register and the SRAM address pins.
- Captures the parallel address once the AVR finishes shifting and asserts sreg_en.
- Drives sram_addr and auto-increments after each completed AVR read or write strobe.
- Lets the AVR stream consecutive bytes without re-shifting an address.

Parameters:
ADDR_W, 21, width of the SRAM address and the counter
INC_STEP, 1, amount added to the address per completed access

Ports:
avr_clk  in  1  system clock, all logic on rising edge
avr_reset  in  1  synchronous reset, active-high
sreg_addr  in  ADDR_W  parallel address from the shift register
sreg_en  in  1  high = address valid/armed; rising edge = load
avr_oe  in  1  AVR read strobe, active-low
avr_we  in  1  AVR write strobe, active-low
inc_en  in  1  high = increment after each access; low = hold address
sram_addr  out  ADDR_W  registered SRAM address
addr_valid  out  1  high while state is ARMED or ACCESS
access_done  out  1  one-cycle pulse at end of each completed access
wrap  out  1  one-cycle pulse when the increment wraps the address to 0

Behaviour:
- Reset (avr_reset=1 at a clock edge):
  - state=IDLE; sram_addr=0; addr_valid=0; access_done=0; wrap=0.
  - Internal sreg_en_d=0, strobe_d=0.
  - Reset overrides all other inputs, including mid-access.
- Registered sampling: sreg_en_d and strobe_d are registered every cycle. strb = exactly one of avr_oe/avr_we low (XOR of the active-low strobes).
- Both strobes low is illegal:
  - Treated as strb=0.
  - Never starts an access.
  - In ACCESS it counts as a strobe release.
- States:
  - IDLE: addr_valid=0; sram_addr holds. sreg_en && !sreg_en_d -> load sram_addr<=sreg_addr, go ARMED.
  - ARMED: addr_valid=1. strb=1 -> ACCESS. sreg_en=0 -> IDLE.
  - ACCESS: addr_valid=1; sram_addr stable for the whole strobe.
    - On strb=0: access_done=1 for one cycle and go ARMED.
    - If inc_en=1 (sampled that cycle): sram_addr<=sram_addr+INC_STEP, modulo 2^ADDR_W.
- Latency:
  - Load: sram_addr shows the new value 1 cycle after the sreg_en rising edge.
  - Increment: new address and access_done appear together, 1 cycle after the strobe release is seen.
- Wrap: if the increment carries out of ADDR_W bits, wrap=1 in the same cycle as access_done.
- Abort: sreg_en=0 while in ACCESS -> IDLE next cycle; no increment, no access_done, sram_addr holds.
- Re-arm: a new sreg_en rising edge in any state reloads sreg_addr and goes ARMED; an in-flight access is dropped with no increment.
- Simultaneous events:
  - Reload takes priority over increment.
  - Increment takes priority over a new strobe, so a back-to-back strobe is seen one cycle later from ARMED.
- Continuous high sreg_en after load causes no further loads; only rising edges load.
- Outputs change only on avr_clk edges; no combinational input-to-output paths.

Optional Feature:
- Macro: SRAM_ADDR_CTR_STATS_EN.
- Defined:
  - Adds output access_cnt [15:0].
  - Cleared on reset and on every load.
  - +1 on each access_done pulse; saturates at 16'hFFFF with no wrap.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then load: avr_reset 1 cycle, sreg_addr=21'h1234A, raise sreg_en -> next cycle sram_addr=21'h1234A, addr_valid=1, access_done=0.
- Read burst: inc_en=1, three pulses of avr_oe low for 2 cycles each -> sram_addr 21'h1234B, 21'h1234C, 21'h1234D; one access_done pulse per release; address stable while avr_oe is low.
- Write, hold mode: inc_en=0, avr_we low 3 cycles then high -> access_done pulses, sram_addr stays 21'h1234A.
- Wrap: load 21'h1FFFFF, one avr_oe pulse with inc_en=1 -> sram_addr=0, wrap=1 and access_done=1 in the same cycle.
- Abort, illegal and reload:
  - avr_oe low, then sreg_en low mid-strobe -> IDLE, no access_done, address unchanged.
  - avr_oe and avr_we both low in ARMED -> no transition.
  - sreg_en re-rise with sreg_addr=21'h00010 -> sram_addr=21'h00010.
- Reset mid-access: assert avr_reset during ACCESS -> next cycle sram_addr=0, addr_valid=0, state IDLE; with SRAM_ADDR_CTR_STATS_EN, access_cnt=0 and it counts 3 after the burst test.

Source files
------------

// File: rtl/sram_addr_ctr_if.sv
// sram_addr_ctr_if: AVR-side address/strobe bundle for the SRAM address stage.
// Optional access_cnt member present when SRAM_ADDR_CTR_STATS_EN is defined.
interface sram_addr_ctr_if #(
    parameter int ADDR_W = 21
);
    logic [ADDR_W-1:0] sreg_addr;
    logic              sreg_en;
    logic              avr_oe;
    logic              avr_we;
    logic              inc_en;
    logic [ADDR_W-1:0] sram_addr;
    logic              addr_valid;
    logic              access_done;
    logic              wrap;
`ifdef SRAM_ADDR_CTR_STATS_EN
    logic [15:0]       access_cnt;
`endif

    modport master (
        output sreg_addr,
        output sreg_en,
        output avr_oe,
        output avr_we,
        output inc_en,
        input  sram_addr,
        input  addr_valid,
        input  access_done,
`ifdef SRAM_ADDR_CTR_STATS_EN
        input  access_cnt,
`endif
        input  wrap
    );

    modport slave (
        input  sreg_addr,
        input  sreg_en,
        input  avr_oe,
        input  avr_we,
        input  inc_en,
        output sram_addr,
        output addr_valid,
        output access_done,
`ifdef SRAM_ADDR_CTR_STATS_EN
        output access_cnt,
`endif
        output wrap
    );
endinterface

// File: rtl/sram_addr_ctr.sv
// sram_addr_ctr: loads the shifted address, drives SRAM address, auto-increments.
// Define SRAM_ADDR_CTR_STATS_EN to add the saturating access_cnt output.
module sram_addr_ctr #(
    parameter int ADDR_W   = 21,
    parameter int INC_STEP = 1
) (
    input logic           avr_clk,
    input logic           avr_reset,
    sram_addr_ctr_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(INC_STEP);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;
    logic              wrap_q;
    logic              sreg_en_d;
    logic              strobe_d;

    logic              strb;
    logic              load;
    logic              release_ev;
    logic              done_ev;
    logic [ADDR_W:0]   sum;

    // Exactly one strobe low is a real access; both low counts as none.
    assign strb = bus.avr_oe ^ bus.avr_we;

    // A new rising edge of sreg_en reloads from any state.
    assign load = bus.sreg_en && !sreg_en_d;

    // Strobe was active last cycle and has now gone away.
    assign release_ev = strobe_d && !strb;

    // Completed access: still armed, strobe released, no reload this cycle.
    assign done_ev = !load && (state == ACCESS) && bus.sreg_en && release_ev;

    assign sum = {1'b0, addr_q} + STEP;

    // Control FSM, address register and one-cycle status pulses.
    always_ff @(posedge avr_clk) begin
        if (avr_reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            sreg_en_d <= 1'b0;
            strobe_d  <= 1'b0;
        end else begin
            sreg_en_d <= bus.sreg_en;
            strobe_d  <= strb;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            if (load) begin
                state  <= ARMED;
                addr_q <= bus.sreg_addr;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ARMED: begin
                        if (!bus.sreg_en)
                            state <= IDLE;
                        else if (strb)
                            state <= ACCESS;
                    end
                    ACCESS: begin
                        if (!bus.sreg_en) begin
                            state <= IDLE;
                        end else if (release_ev) begin
                            state  <= ARMED;
                            done_q <= 1'b1;
                            if (bus.inc_en) begin
                                addr_q <= sum[ADDR_W-1:0];
                                wrap_q <= sum[ADDR_W];
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SRAM_ADDR_CTR_STATS_EN
    logic [15:0] cnt_q;

    // Count completed accesses since the last load, saturating at all-ones.
    always_ff @(posedge avr_clk) begin
        if (avr_reset || load)
            cnt_q <= '0;
        else if (done_ev && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign bus.access_cnt = cnt_q;
`endif

    assign bus.sram_addr   = addr_q;
    assign bus.addr_valid  = (state != IDLE);
    assign bus.access_done = done_q;
    assign bus.wrap        = wrap_q;

endmodule
